// File: rtl/mem_responder.sv
// Multicycle memory responder with programmable wait states and a word array.
// Define MEM_RESP_ALIGN_CHECK_EN to flag and suppress misaligned accesses.
module mem_responder #(
    parameter int unsigned ADDR_WORDS  = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int unsigned AW = $clog2(ADDR_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            mis_q, mis_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic            mem_we;
    logic            mis_in;
    logic            unused_addr;
    logic [31:0]     mem_q [ADDR_WORDS];

`ifdef MEM_RESP_ALIGN_CHECK_EN
    assign mis_in      = |addr[1:0];
    assign unused_addr = ^addr[31:AW+2];
`else
    assign mis_in      = 1'b0;
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        mis_d   = mis_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    idx_d   = addr[AW+1:2];
                    mis_d   = mis_in;
                    wdata_d = wdata;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                busy_d  = 1'b1;
                ready_d = 1'b1;
                err_d   = mis_q;
                state_d = RESP;
                // Misaligned requests never touch the array.
                if (mis_q) begin
                    rdata_d = 32'h0;
                end else if (wr_q) begin
                    mem_we = 1'b1;
                end else begin
                    rdata_d = mem_q[idx_q];
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            mis_q   <= 1'b0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            mis_q   <= mis_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule
